avm_pio_master: RTL

//  Avalon-MM master (initiator) that turns single-beat commands into read/write transfers on an Avalon-MM slave bus.

---
 rtl/avm_pio_master_pkg.sv | 20 ++
 rtl/avm_stall_timer.sv | 39 +++
 rtl/avm_pio_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/avm_pio_master_pkg.sv
// Shared types and widths for the Avalon-MM PIO master and its stall timer.
package avm_pio_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDLAT = 2'd2,
    RSP   = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;
  localparam int LAT_W      = 3;
  localparam int TO_W       = 16;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/avm_stall_timer.sv
// Counts consecutive waitrequest stalls of one bus request and flags the cycle
// in which the stall count reaches TIMEOUT_CYCLES.
module avm_stall_timer
  import avm_pio_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic stall,
  output logic expired
);

  logic [TO_W-1:0] cnt_reg;
  logic [TO_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (stall) begin
      cnt_next = cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Fires during the stall cycle whose edge brings the count to TIMEOUT_CYCLES,
  // so the request is dropped right at that edge.
  assign expired = stall && (cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/avm_pio_master.sv
// Avalon-MM PIO master: one single-beat command in, one bus transfer, one response out.
// Define MASTER_TIMEOUT_EN to abort requests stalled by waitrequest for TIMEOUT_CYCLES.
module avm_pio_master
  import avm_pio_master_pkg::*;
#(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 32,
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_writedata,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_readdata,
  output logic                rsp_error,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [DATA_W-1:0]     wdata_reg, wdata_next;
  logic [DATA_W/8-1:0]   be_reg, be_next;
  logic                  write_reg, write_next;
  logic [LAT_W-1:0]      lat_reg, lat_next;
  logic [DATA_W-1:0]     rdata_reg, rdata_next;
  logic                  timeout_hit;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    write_next = write_reg;
    lat_next   = lat_reg;
    rdata_next = rdata_reg;
    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next  = cmd_address;
          wdata_next = cmd_writedata;
          be_next    = cmd_byteenable;
          write_next = cmd_write;
          state_next = REQ;
        end
      end
      REQ: begin
        if (timeout_hit) begin
          rdata_next = '0;
          state_next = RSP;
        end else if (!avm_waitrequest) begin
          if (write_reg) begin
            rdata_next = '0;
            state_next = RSP;
          end else if (READ_LATENCY == 0) begin
            rdata_next = avm_readdata;
            state_next = RSP;
          end else begin
            lat_next   = LAT_W'(1);
            state_next = RDLAT;
          end
        end
      end
      RDLAT: begin
        if (lat_reg == LAT_W'(READ_LATENCY)) begin
          rdata_next = avm_readdata;
          state_next = RSP;
        end else begin
          lat_next = lat_reg + LAT_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      write_reg <= 1'b0;
      lat_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      write_reg <= write_next;
      lat_reg   <= lat_next;
      rdata_reg <= rdata_next;
    end
  end

  // Gating with reset keeps cmd_ready low while reset is held even though the state already reads IDLE.
  assign cmd_ready      = (state_reg == IDLE) && !reset;
  assign rsp_valid      = (state_reg == RSP);
  assign rsp_readdata   = rdata_reg;
  assign avm_read       = (state_reg == REQ) && !write_reg;
  assign avm_write      = (state_reg == REQ) && write_reg;
  assign avm_address    = addr_reg;
  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = be_reg;

`ifdef MASTER_TIMEOUT_EN
  logic err_reg;
  logic stall_clr;
  logic stall_active;

  assign stall_clr    = (state_reg != REQ);
  assign stall_active = (state_reg == REQ) && avm_waitrequest;

  avm_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (stall_clr),
    .stall   (stall_active),
    .expired (timeout_hit)
  );

  // Only REQ can end in an abort; the flag then holds through RSP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == REQ) begin
      err_reg <= timeout_hit;
    end
  end

  assign rsp_error = err_reg;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign rsp_error          = 1'b0;
`endif

endmodule
